// File: rtl/dds_mod_sequencer.sv
// Streaming phase-word sequencer for a phase-input DDS compiler.
// Generates SIN / BPSK / 2-FSK / LFM phase sequences with AXI-Stream flow control.
module dds_mod_sequencer #(
    parameter int PHASE_W = 16,
    parameter int MSG_W   = 13,
    parameter int CNT_W   = 16
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_cmd_tvalid,
    output logic               s_cmd_tready,
    input  logic [1:0]         cmd_mode,
    input  logic [PHASE_W-1:0] cmd_incr0,
    input  logic [PHASE_W-1:0] cmd_incr1,
    input  logic [PHASE_W-1:0] cmd_step,
    input  logic [MSG_W-1:0]   cmd_message,
    input  logic [4:0]         cmd_nbits,
    input  logic [CNT_W-1:0]   cmd_len,
    input  logic               abort,
    output logic [PHASE_W-1:0] m_axis_phase_tdata,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SIN = 2'd0;
    localparam logic [1:0] MODE_PSK = 2'd1;
    localparam logic [1:0] MODE_FSK = 2'd2;
    localparam logic [1:0] MODE_LFM = 2'd3;

    localparam logic [PHASE_W-1:0] PSK_FLIP  = {1'b1, {(PHASE_W-1){1'b0}}};
    localparam logic [PHASE_W-1:0] PHASE_ZERO = '0;
    localparam logic [4:0]         MSG_MAX   = 5'(MSG_W);

    state_t             r_state;
    state_t             w_stateNext;

    logic [1:0]         r_mode;
    logic [PHASE_W-1:0] r_incr0;
    logic [PHASE_W-1:0] r_incr1;
    logic [PHASE_W-1:0] r_step;
    logic [PHASE_W-1:0] r_curInc;
    logic [PHASE_W-1:0] r_tdata;
    logic [MSG_W-1:0]   r_msg;
    logic [4:0]         r_bitIdx;
    logic [4:0]         r_nbitsM1;
    logic [CNT_W-1:0]   r_sampleCnt;
    logic [CNT_W-1:0]   r_lenM1;

    logic               w_accept;
    logic               w_cmdBitMode;
    logic [4:0]         w_nbitsClamped;
    logic               w_degenerate;
    logic               w_firstBit;
    logic [PHASE_W-1:0] w_firstInc;
    logic [PHASE_W-1:0] w_firstPsk;
    logic [PHASE_W-1:0] w_firstSample;

    logic               w_fire;
    logic               w_bitMode;
    logic               w_cntWrap;
    logic               w_lastBit;
    logic               w_final;
    logic               w_advanceBit;
    logic               w_nextBit;
    logic [PHASE_W-1:0] w_nextInc;
    logic [PHASE_W-1:0] w_nextPsk;
    logic [PHASE_W-1:0] w_nextSample;

    // Command decode: the first sample is computed straight from the command
    // fields so it can be presented in the cycle right after acceptance.
    assign w_accept       = (r_state == ST_IDLE) && s_cmd_tvalid;
    assign w_cmdBitMode   = (cmd_mode == MODE_PSK) || (cmd_mode == MODE_FSK);
    assign w_nbitsClamped = (cmd_nbits > MSG_MAX) ? MSG_MAX : cmd_nbits;
    assign w_degenerate   = (cmd_len == '0) || (w_cmdBitMode && (w_nbitsClamped == 5'd0));
    assign w_firstBit     = cmd_message[0];
    assign w_firstInc     = ((cmd_mode == MODE_FSK) && !w_firstBit) ? cmd_incr1 : cmd_incr0;
    assign w_firstPsk     = ((cmd_mode == MODE_PSK) && w_firstBit) ? PSK_FLIP : PHASE_ZERO;
    assign w_firstSample  = w_firstInc + w_firstPsk;

    assign w_fire       = (r_state == ST_RUN) && m_axis_phase_tready;
    assign w_bitMode    = (r_mode == MODE_PSK) || (r_mode == MODE_FSK);
    assign w_cntWrap    = (r_sampleCnt == r_lenM1);
    assign w_lastBit    = (r_bitIdx == r_nbitsM1);
    assign w_final      = w_cntWrap && (!w_bitMode || w_lastBit);
    assign w_advanceBit = w_bitMode && w_cntWrap;
    // The message register shifts right per bit, so the upcoming bit is [1] on a bit boundary.
    assign w_nextBit    = w_advanceBit ? r_msg[1] : r_msg[0];
    assign w_nextPsk    = ((r_mode == MODE_PSK) && w_advanceBit && w_nextBit) ? PSK_FLIP : PHASE_ZERO;
    assign w_nextSample = r_tdata + w_nextInc + w_nextPsk;

    always_comb begin
        w_nextInc = r_incr0;
        case (r_mode)
            MODE_SIN: w_nextInc = r_incr0;
            MODE_PSK: w_nextInc = r_incr0;
            MODE_FSK: w_nextInc = w_nextBit ? r_incr0 : r_incr1;
            MODE_LFM: w_nextInc = r_curInc + r_step;
            default:  w_nextInc = r_incr0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext         = r_state;
        s_cmd_tready        = 1'b0;
        busy                = 1'b0;
        m_axis_phase_tvalid = 1'b0;
        done                = 1'b0;
        case (r_state)
            ST_IDLE: begin
                s_cmd_tready = 1'b1;
                if (s_cmd_tvalid) begin
                    w_stateNext = w_degenerate ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy                = 1'b1;
                m_axis_phase_tvalid = 1'b1;
                if (abort) begin
                    w_stateNext = ST_IDLE;
                end else if (w_fire && w_final) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Datapath only moves on a consumed sample, so a stalled DDS sees stable tdata.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_mode      <= '0;
            r_incr0     <= '0;
            r_incr1     <= '0;
            r_step      <= '0;
            r_curInc    <= '0;
            r_tdata     <= '0;
            r_msg       <= '0;
            r_bitIdx    <= '0;
            r_nbitsM1   <= '0;
            r_sampleCnt <= '0;
            r_lenM1     <= '0;
        end else if (w_accept) begin
            r_mode      <= cmd_mode;
            r_incr0     <= cmd_incr0;
            r_incr1     <= cmd_incr1;
            r_step      <= cmd_step;
            r_curInc    <= cmd_incr0;
            r_tdata     <= w_firstSample;
            r_msg       <= cmd_message;
            r_bitIdx    <= '0;
            r_nbitsM1   <= w_nbitsClamped - 5'd1;
            r_sampleCnt <= '0;
            r_lenM1     <= cmd_len - CNT_W'(1);
        end else if (r_state == ST_RUN) begin
            if (abort) begin
                r_tdata <= '0;
            end else if (w_fire && !w_final) begin
                r_tdata  <= w_nextSample;
                r_curInc <= w_nextInc;
                if (w_advanceBit) begin
                    r_sampleCnt <= '0;
                    r_bitIdx    <= r_bitIdx + 5'd1;
                    r_msg       <= r_msg >> 1;
                end else begin
                    r_sampleCnt <= r_sampleCnt + CNT_W'(1);
                end
            end
        end
    end

    assign m_axis_phase_tdata = r_tdata;

endmodule

// File: tb/tb_dds_mod_sequencer.sv
// Self-checking bench for dds_mod_sequencer: a sample-list model built from the
// modulation rules, checked every valid cycle, plus directed literal expectations.
module tb_dds_mod_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_incr0;
    logic [15:0] cmd_incr1;
    logic [15:0] cmd_step;
    logic [12:0] cmd_message;
    logic [4:0]  cmd_nbits;
    logic [15:0] cmd_len;
    logic        abort;
    logic [15:0] m_axis_phase_tdata;
    logic        m_axis_phase_tvalid;
    logic        m_axis_phase_tready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int doneCount = 0;
    int doneCycle = 0;
    int busyCount = 0;

    logic [15:0] expQ[$];
    logic [15:0] gotQ[$];
    logic [15:0] wantQ[$];

    dds_mod_sequencer dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_cmd_tvalid       (s_cmd_tvalid),
        .s_cmd_tready       (s_cmd_tready),
        .cmd_mode           (cmd_mode),
        .cmd_incr0          (cmd_incr0),
        .cmd_incr1          (cmd_incr1),
        .cmd_step           (cmd_step),
        .cmd_message        (cmd_message),
        .cmd_nbits          (cmd_nbits),
        .cmd_len            (cmd_len),
        .abort              (abort),
        .m_axis_phase_tdata (m_axis_phase_tdata),
        .m_axis_phase_tvalid(m_axis_phase_tvalid),
        .m_axis_phase_tready(m_axis_phase_tready),
        .busy               (busy),
        .done               (done)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Expected phase words from the modulation rules: sample k of bit k/len.
    task automatic modelCommand(input logic [1:0] mode, input logic [15:0] i0, input logic [15:0] i1,
                                input logic [15:0] st, input logic [12:0] msg, input logic [4:0] nb,
                                input logic [15:0] len);
        int nbEff = (nb > 5'd13) ? 13 : int'(nb);
        int lenI = int'(len);
        bit bitMode = (mode == 2'd1) || (mode == 2'd2);
        int total = bitMode ? nbEff * lenI : lenI;
        logic [15:0] acc = 16'd0;
        logic [15:0] inc;
        int bitNo;
        logic bitv;
        for (int k = 0; k < total; k++) begin
            bitNo = bitMode ? k / lenI : 0;
            bitv = msg[bitNo];
            case (mode)
                2'd2:    inc = bitv ? i0 : i1;
                2'd3:    inc = i0 + 16'(k) * st;
                default: inc = i0;
            endcase
            acc = acc + inc;
            if (mode == 2'd1 && (k % lenI) == 0 && bitv) acc = acc + 16'h8000;
            expQ.push_back(acc);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] i0, input logic [15:0] i1,
                                 input logic [15:0] st, input logic [12:0] msg, input logic [4:0] nb,
                                 input logic [15:0] len, output int acceptAt);
        int n = 0;
        logic rdy = 1'b0;
        modelCommand(mode, i0, i1, st, msg, nb, len);
        cmd_mode = mode; cmd_incr0 = i0; cmd_incr1 = i1; cmd_step = st;
        cmd_message = msg; cmd_nbits = nb; cmd_len = len;
        s_cmd_tvalid = 1'b1;
        while (!rdy && n < 50) begin
            @(negedge aclk);
            rdy = s_cmd_tready;
            @(posedge aclk);
            #1;
            n++;
        end
        s_cmd_tvalid = 1'b0;
        checkOutput("cmd_accepted", {31'd0, rdy}, 32'd1);
        acceptAt = cycle;
    endtask

    task automatic waitDone(input string name, input int startDone, input int maxCyc);
        int n = 0;
        while (doneCount == startDone && n < maxCyc) begin
            @(posedge aclk);
            n++;
        end
        #1;
        checkOutput({name, "_done_seen"}, doneCount - startDone, 1);
    endtask

    task automatic checkGot(input string name);
        checkOutput({name, "_count"}, gotQ.size(), wantQ.size());
        for (int i = 0; i < gotQ.size() && i < wantQ.size(); i++)
            checkOutput({name, "_sample"}, gotQ[i], wantQ[i]);
        checkOutput({name, "_model_drained"}, expQ.size(), 0);
        gotQ.delete();
        wantQ.delete();
    endtask

    // Every valid cycle: tdata must match the oldest unconsumed model sample.
    always @(negedge aclk) begin
        if (!areset) begin
            if (done) begin
                doneCount++;
                doneCycle = cycle;
            end
            if (busy) busyCount++;
            if (m_axis_phase_tvalid) begin
                checkOutput("model_has_sample", {31'd0, expQ.size() > 0}, 32'd1);
                checkOutput("busy_with_valid", {31'd0, busy}, 32'd1);
                if (expQ.size() > 0) checkOutput("tdata_vs_model", m_axis_phase_tdata, expQ[0]);
                if (abort) begin
                    expQ.delete();
                end else if (m_axis_phase_tready) begin
                    gotQ.push_back(m_axis_phase_tdata);
                    if (expQ.size() > 0) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int d0;
        int b0;
        areset = 1'b1; s_cmd_tvalid = 1'b0; abort = 1'b0; m_axis_phase_tready = 1'b1;
        cmd_mode = 2'd0; cmd_incr0 = '0; cmd_incr1 = '0; cmd_step = '0;
        cmd_message = '0; cmd_nbits = '0; cmd_len = '0;
        #12;
        checkOutput("rst_tready", {31'd0, s_cmd_tready}, 32'd1);
        checkOutput("rst_tvalid", {31'd0, m_axis_phase_tvalid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_tdata", m_axis_phase_tdata, 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;

        $display("[TB] SIN tone");
        d0 = doneCount; b0 = busyCount;
        applyStimulus(2'd0, 16'd1310, 16'd0, 16'd0, 13'd0, 5'd0, 16'd4, acc);
        @(negedge aclk);
        checkOutput("sin_first_valid", {31'd0, m_axis_phase_tvalid}, 32'd1);
        checkOutput("sin_first_tdata", m_axis_phase_tdata, 32'd1310);
        waitDone("sin", d0, 20);
        checkOutput("sin_done_offset", doneCycle - acc, 4);
        checkOutput("sin_busy_cycles", busyCount - b0, 4);
        @(posedge aclk); @(posedge aclk); #1;
        checkOutput("sin_done_once", doneCount - d0, 1);
        wantQ = '{16'd1310, 16'd2620, 16'd3930, 16'd5240};
        checkGot("sin");

        $display("[TB] BPSK");
        d0 = doneCount;
        applyStimulus(2'd1, 16'd6553, 16'd0, 16'd0, 13'b01, 5'd2, 16'd2, acc);
        waitDone("psk", d0, 20);
        @(posedge aclk); @(posedge aclk); #1;
        checkOutput("psk_done_once", doneCount - d0, 1);
        wantQ = '{16'd39321, 16'd45874, 16'd52427, 16'd58980};
        checkGot("psk");

        $display("[TB] 2-FSK");
        d0 = doneCount;
        applyStimulus(2'd2, 16'd2621, 16'd6553, 16'd0, 13'b10, 5'd2, 16'd2, acc);
        waitDone("fsk", d0, 20);
        wantQ = '{16'd6553, 16'd13106, 16'd15727, 16'd18348};
        checkGot("fsk");

        $display("[TB] LFM with wrap");
        d0 = doneCount;
        applyStimulus(2'd3, 16'hF000, 16'd0, 16'h0010, 13'd0, 5'd0, 16'd3, acc);
        waitDone("lfm", d0, 20);
        wantQ = '{16'hF000, 16'hE010, 16'hD030};
        checkGot("lfm");

        $display("[TB] FSK nbits clamp");
        d0 = doneCount;
        applyStimulus(2'd2, 16'd1000, 16'd3000, 16'd0, 13'h1555, 5'd20, 16'd1, acc);
        waitDone("clamp", d0, 40);
        checkOutput("clamp_count", gotQ.size(), 13);
        checkOutput("clamp_first", gotQ.size() > 0 ? gotQ[0] : 16'd0, 32'd1000);
        checkOutput("clamp_second", gotQ.size() > 1 ? gotQ[1] : 16'd0, 32'd4000);
        gotQ.delete();
        checkOutput("clamp_model_drained", expQ.size(), 0);

        $display("[TB] backpressure");
        d0 = doneCount;
        applyStimulus(2'd0, 16'd100, 16'd0, 16'd0, 13'd0, 5'd0, 16'd5, acc);
        @(posedge aclk); #1;
        m_axis_phase_tready = 1'b0;
        cmd_mode = 2'd0; cmd_incr0 = 16'd9; cmd_len = 16'd2;
        s_cmd_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checkOutput("bp_hold_tdata", m_axis_phase_tdata, 32'd200);
            checkOutput("bp_hold_valid", {31'd0, m_axis_phase_tvalid}, 32'd1);
            checkOutput("bp_cmd_blocked", {31'd0, s_cmd_tready}, 32'd0);
            @(posedge aclk); #1;
        end
        s_cmd_tvalid = 1'b0;
        m_axis_phase_tready = 1'b1;
        waitDone("bp", d0, 20);
        wantQ = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
        checkGot("bp");

        $display("[TB] abort");
        d0 = doneCount;
        applyStimulus(2'd0, 16'd500, 16'd0, 16'd0, 13'd0, 5'd0, 16'd6, acc);
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        abort = 1'b1;
        @(negedge aclk);
        checkOutput("abort_third_sample", m_axis_phase_tdata, 32'd1500);
        @(posedge aclk); #1;
        abort = 1'b0;
        @(negedge aclk);
        checkOutput("abort_tvalid", {31'd0, m_axis_phase_tvalid}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_tdata", m_axis_phase_tdata, 32'd0);
        checkOutput("abort_tready", {31'd0, s_cmd_tready}, 32'd1);
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("abort_no_done", doneCount - d0, 0);
        wantQ = '{16'd500, 16'd1000};
        checkGot("abort");
        d0 = doneCount;
        applyStimulus(2'd0, 16'd7, 16'd0, 16'd0, 13'd0, 5'd0, 16'd2, acc);
        waitDone("post_abort", d0, 20);
        wantQ = '{16'd7, 16'd14};
        checkGot("post_abort");

        $display("[TB] degenerate commands");
        d0 = doneCount; b0 = busyCount;
        abort = 1'b1;
        applyStimulus(2'd0, 16'd55, 16'd0, 16'd0, 13'd0, 5'd0, 16'd0, acc);
        waitDone("len0", d0, 10);
        abort = 1'b0;
        checkOutput("len0_done_offset", doneCycle - acc, 0);
        checkOutput("len0_busy_cycles", busyCount - b0, 0);
        checkGot("len0");
        d0 = doneCount;
        applyStimulus(2'd1, 16'd55, 16'd0, 16'd0, 13'h1F, 5'd0, 16'd3, acc);
        waitDone("nbits0", d0, 10);
        checkOutput("nbits0_done_offset", doneCycle - acc, 0);
        checkGot("nbits0");

        $display("[TB] reset mid-run");
        d0 = doneCount;
        applyStimulus(2'd3, 16'd100, 16'd0, 16'd1, 13'd0, 5'd0, 16'd20, acc);
        repeat (3) @(posedge aclk);
        #3;
        areset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midrst_tready", {31'd0, s_cmd_tready}, 32'd1);
        checkOutput("midrst_tvalid", {31'd0, m_axis_phase_tvalid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, done}, 32'd0);
        checkOutput("midrst_tdata", m_axis_phase_tdata, 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        gotQ.delete();
        repeat (2) @(posedge aclk);
        #1;
        checkOutput("midrst_no_done", doneCount - d0, 0);
        d0 = doneCount;
        applyStimulus(2'd0, 16'd3, 16'd0, 16'd0, 13'd0, 5'd0, 16'd1, acc);
        waitDone("post_rst", d0, 10);
        wantQ = '{16'd3};
        checkGot("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
